// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The controller drives the master side; the datapath connects to the slave side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zFlag;
    logic             mem_ready;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       ImmSrc;
    logic             RegWrite;
    logic [3:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zFlag, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, state, halted, instr_count
    );

    modport slave (
        output opcode, zFlag, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, state, halted, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I datapath with a shared memory.
// Moore controls are registered from the next state; memory-ready and zFlag terms are gated in combinationally.
module multicycle_ctrl #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef struct packed {
        logic       is_fetch;
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.is_fetch = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            ALUWB:    c.reg_write = 1'b1;
            JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
            BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t           state, next_state;
    ctl_t             ctl_q;
    logic             halted_q;
    logic             retire;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            FETCH:    if (bus.mem_ready) next_state = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_I:         next_state = EXECUTEI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    default: begin
                        if (HALT_ON_ILLEGAL) begin
                            next_state = HALT;
                        end else begin
                            next_state = FETCH;
                            retire     = 1'b1;
                        end
                    end
                endcase
            end
            MEMADR:   next_state = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (bus.mem_ready) next_state = MEMWB;
            MEMWB:    begin next_state = FETCH; retire = 1'b1; end
            MEMWRITE: if (bus.mem_ready) begin next_state = FETCH; retire = 1'b1; end
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            ALUWB:    begin next_state = FETCH; retire = 1'b1; end
            JAL:      next_state = ALUWB;
            BEQ:      begin next_state = FETCH; retire = 1'b1; end
            HALT:     next_state = HALT;
            default:  next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            ctl_q    <= decode(FETCH);
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= next_state;
            ctl_q    <= decode(next_state);
            halted_q <= (next_state == HALT);
            if (retire) count_q <= count_q + 1'b1;
        end
    end

    // Enables are masked by rst so nothing writes while reset is held.
    assign bus.PCWrite  = ~rst & ((ctl_q.is_fetch & bus.mem_ready) | ctl_q.pc_update |
                                  (ctl_q.branch & bus.zFlag));
    assign bus.IRWrite  = ~rst & ctl_q.is_fetch & bus.mem_ready;
    assign bus.MemWrite = ~rst & ctl_q.mem_write;
    assign bus.RegWrite = ~rst & ctl_q.reg_write;

    assign bus.AdrSrc      = ctl_q.adr_src;
    assign bus.ResultSrc   = ctl_q.result_src;
    assign bus.ALUSrcA     = ctl_q.alu_src_a;
    assign bus.ALUSrcB     = ctl_q.alu_src_b;
    assign bus.ALUOp       = ctl_q.alu_op;
    assign bus.state       = state;
    assign bus.halted      = halted_q;
    assign bus.instr_count = count_q;

    always_comb begin
        case (bus.opcode)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw;
        logic        adr;
        logic        memw;
        logic        irw;
        logic [1:0]  res;
        logic [1:0]  srca;
        logic [1:0]  srcb;
        logic [1:0]  aluop;
        logic [1:0]  imm;
        logic        regw;
        logic        halted;
        logic [31:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();
    multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t        exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] m_cnt;
    logic [6:0]  cur_op;
    logic [6:0]  legal_ops[6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected outputs for one cycle, taken from the per-state control table.
    function automatic obs_t model(int st, logic [6:0] op, logic mr, logic z, logic r,
                                   logic [31:0] cnt);
        obs_t o;
        o        = '0;
        o.st     = st[3:0];
        o.cnt    = cnt;
        o.halted = (st == 11);
        if (op == OP_SW)       o.imm = 2'b01;
        else if (op == OP_BEQ) o.imm = 2'b10;
        else if (op == OP_JAL) o.imm = 2'b11;
        case (st)
            0:  begin o.srcb = 2'd2; o.res = 2'd2; o.irw = mr; o.pcw = mr; end
            1:  begin o.srca = 2'd1; o.srcb = 2'd1; end
            2:  begin o.srca = 2'd2; o.srcb = 2'd1; end
            3:  o.adr = 1'b1;
            4:  begin o.res = 2'd1; o.regw = 1'b1; end
            5:  begin o.adr = 1'b1; o.memw = 1'b1; end
            6:  begin o.srca = 2'd2; o.aluop = 2'd2; end
            7:  begin o.srca = 2'd2; o.srcb = 2'd1; o.aluop = 2'd2; end
            8:  o.regw = 1'b1;
            9:  begin o.srca = 2'd1; o.srcb = 2'd2; o.pcw = 1'b1; end
            10: begin o.srca = 2'd2; o.aluop = 2'd1; o.pcw = z; end
            default: ;
        endcase
        if (r) begin
            o.pcw  = 1'b0;
            o.irw  = 1'b0;
            o.memw = 1'b0;
            o.regw = 1'b0;
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.st     = bus.state;
        a.pcw    = bus.PCWrite;
        a.adr    = bus.AdrSrc;
        a.memw   = bus.MemWrite;
        a.irw    = bus.IRWrite;
        a.res    = bus.ResultSrc;
        a.srca   = bus.ALUSrcA;
        a.srcb   = bus.ALUSrcB;
        a.aluop  = bus.ALUOp;
        a.imm    = bus.ImmSrc;
        a.regw   = bus.RegWrite;
        a.halted = bus.halted;
        a.cnt    = bus.instr_count;
        return a;
    endfunction

    task automatic step(int st, logic mr, logic z, bit ret);
        rst           = 1'b0;
        bus.opcode    = cur_op;
        bus.mem_ready = mr;
        bus.zFlag     = z;
        exp_q.push_back(model(st, cur_op, mr, z, 1'b0, m_cnt));
        if (ret) m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step(int st, logic mr);
        logic z;
        z             = rb();
        rst           = 1'b1;
        bus.opcode    = cur_op;
        bus.mem_ready = mr;
        bus.zFlag     = z;
        exp_q.push_back(model(st, cur_op, mr, z, 1'b1, m_cnt));
        m_cnt = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(logic [6:0] op, int wf, int wm, logic zb);
        cur_op = op;
        for (int i = 0; i < wf; i++) step(0, 1'b0, rb(), 1'b0);
        step(0, 1'b1, rb(), 1'b0);
        step(1, rb(), rb(), 1'b0);
        case (op)
            OP_LW: begin
                step(2, rb(), rb(), 1'b0);
                for (int i = 0; i < wm; i++) step(3, 1'b0, rb(), 1'b0);
                step(3, 1'b1, rb(), 1'b0);
                step(4, rb(), rb(), 1'b1);
            end
            OP_SW: begin
                step(2, rb(), rb(), 1'b0);
                for (int i = 0; i < wm; i++) step(5, 1'b0, rb(), 1'b0);
                step(5, 1'b1, rb(), 1'b1);
            end
            OP_R:   begin step(6, rb(), rb(), 1'b0); step(8, rb(), rb(), 1'b1); end
            OP_I:   begin step(7, rb(), rb(), 1'b0); step(8, rb(), rb(), 1'b1); end
            OP_JAL: begin step(9, rb(), rb(), 1'b0); step(8, rb(), rb(), 1'b1); end
            OP_BEQ: step(10, rb(), zb, 1'b1);
            default: for (int i = 0; i < 4; i++) step(11, rb(), rb(), 1'b0);
        endcase
    endtask

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample();
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_check st=%0d got=%h expected=%h", e.st, a, e);
                end
            end
        end
    end

    initial begin : stimulus
        rst           = 1'b1;
        cur_op        = OP_R;
        bus.opcode    = OP_R;
        bus.mem_ready = 1'b1;
        bus.zFlag     = 1'b0;
        m_cnt         = '0;
        @(posedge clk);
        #1;
        rst_step(0, 1'b1);
        rst_step(0, 1'b1);

        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_LW, 0, 3, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_SW, 0, 2, 1'b0);
        run_instr(OP_I, 1, 0, 1'b0);
        run_instr(OP_JAL, 2, 1, 1'b0);

        // Reset lands on a store that is completing; it must neither write nor retire.
        cur_op = OP_SW;
        step(0, 1'b1, rb(), 1'b0);
        step(1, rb(), rb(), 1'b0);
        step(2, rb(), rb(), 1'b0);
        rst_step(5, 1'b1);

        for (int n = 0; n < 300; n++)
            run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 3), rb());

        run_instr(7'b0000000, 0, 0, 1'b0);
        rst_step(11, 1'b1);
        run_instr(OP_R, 0, 0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM that sequences the RV32I datapath as a multi-cycle machine with one shared instruction/data memory.
- Drives all datapath enables and mux selects: PC write, instruction-register write, memory address select, ALU operand selects, ALUOp, result select, register-file write.
- Stalls on a memory-ready handshake, counts retired instructions, and halts on an unsupported opcode.
- Sits beside the existing ALU decoder, which still turns ALUOp, func3, op5 and func7_5 into ALUControl.

Parameters:
CNT_W, 32, width of the retired-instruction counter.
HALT_ON_ILLEGAL, 1, 1 = unsupported opcode enters HALT; 0 = it is treated as a NOP and the FSM returns to FETCH.

Ports:
clk  input  1  system clock, all state changes on the rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  instr[6:0] from the instruction register
zFlag  input  1  ALU zero flag
mem_ready  input  1  shared memory completes the current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register (and OldPC) enable
ResultSrc  output  2  00 = ALUOut register, 01 = memory data register, 10 = ALU result
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1 register
ALUSrcB  output  2  00 = RD2 register, 01 = ImmExt, 10 = constant 4
ALUOp  output  2  to the ALU decoder
ImmSrc  output  2  to the sign extender
RegWrite  output  1  register-file write enable
state  output  4  current state code, for debug
halted  output  1  FSM is in HALT
instr_count  output  CNT_W  retired-instruction counter

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10, HALT=11. Codes 12-15 go to FETCH on the next edge.
- Reset: rst sampled high at an edge sets state=FETCH, instr_count=0, halted=0. While rst is high, all enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0. rst overrides every other event, including a pending mem_ready.
- Outputs decode combinationally from state (Moore), except:
  - ImmSrc decodes from opcode in all states: lw or I-type 00, sw 01, beq 10, jal 11, others 00.
  - PCWrite = PCUpdate | (Branch & zFlag).
- Unlisted outputs are 0 in each state.
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-type ALU 0010011, jal 1101111, beq 1100011.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCUpdate equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target precomputed). Next state by opcode:
  - lw or sw -> MEMADR; R-type -> EXECUTER; I-type -> EXECUTEI; jal -> JAL; beq -> BEQ.
  - Any other opcode -> HALT if HALT_ON_ILLEGAL=1, else FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 and held every cycle until mem_ready=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then FETCH.
- HALT: all enables 0, halted=1. Remains in HALT until rst.
- Retire: instr_count increments by 1 on any edge where the next state is FETCH from MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BEQ, and on the illegal-as-NOP DECODE->FETCH transition.
  - instr_count wraps modulo 2^CNT_W.
  - Stall cycles and HALT do not count.
- Cycles per instruction with mem_ready tied to 1: lw 5, sw 4, R/I-type 4, jal 4, beq 3. Each memory wait cycle adds 1.

Test Plan:
- Hold rst for 2 cycles, then release with mem_ready=1 -> state=0 and all enables 0 during reset; PCWrite=IRWrite=1 in the first FETCH cycle.
- R-type add (opcode 0110011), mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; instr_count=1.
- lw with mem_ready low for 3 cycles in MEMREAD -> state stays 3 for 3 cycles; MEMWB follows with ResultSrc=01, RegWrite=1; instr_count increments once.
- beq with zFlag=1 then zFlag=0 -> PCWrite=1 in BEQ only when zFlag=1; 3 cycles each.
- sw with mem_ready=0 for 2 cycles -> MemWrite=1 for 3 consecutive cycles in state 5; no RegWrite.
- Opcode 0000000 with HALT_ON_ILLEGAL=1 -> halted=1, state=11, instr_count frozen; assert rst for one cycle -> state=0, halted=0, instr_count=0.
